// File: rtl/srx_pkg.sv
// srx_pkg: shared frame geometry, per-digit field offsets and receiver state type.
package srx_pkg;
    localparam int FRAME_BITS  = 96;
    localparam int DIGIT_BITS  = 24;
    localparam int RED_LSB     = 16;
    localparam int RED_W       = 7;
    localparam int GRN_LSB     = 8;
    localparam int GRN_W       = 7;
    localparam int AN_LSB      = 0;
    localparam int AN_W        = 6;

    typedef enum logic {IDLE, SHIFT} srx_state_e;

    // Digit 0 is the first digit on the wire and occupies the top 24 bits.
    function automatic int digit_base(input int d);
        return FRAME_BITS - DIGIT_BITS * (d + 1);
    endfunction
endpackage

// File: rtl/srx_sync_edge.sv
// srx_sync_edge: 2-flop synchroniser with a history flop for rise detection.
module srx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic s_o,
    output logic rise_o
);
    logic [2:0] s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= '0;
        else s_q <= {s_q[1:0], d_i};
    end

    assign s_o    = s_q[1];
    assign rise_o = s_q[1] & ~s_q[2];
endmodule

// File: rtl/srx_frame_rx.sv
// srx_frame_rx: oversampled MCU serial frame receiver with length validation.
// Define SRX_TIMEOUT_EN to abandon frames left idle for TIMEOUT_CYC cycles.
module srx_frame_rx #(
    parameter int FRAME_BITS  = srx_pkg::FRAME_BITS,
    parameter int ERR_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  sdata,
    input  logic                  slatch,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  busy
);
    import srx_pkg::*;

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_OVF  = CW'(FRAME_BITS + 1);

    logic sck_s, sck_rise, sdata_s, sdata_rise, latch_s, latch_rise;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d, frame_q;
    logic [CW-1:0] cnt_q, cnt_sh, cnt_d;
    logic [ERR_W-1:0] err_q;
    logic valid_q, err_pulse_q, busy_q, timeout, accept, reject;
    srx_state_e state_q, state_d;

    srx_sync_edge u_sck   (.clk(clk), .rst_n(rst_n), .d_i(sck),    .s_o(sck_s),   .rise_o(sck_rise));
    srx_sync_edge u_sdata (.clk(clk), .rst_n(rst_n), .d_i(sdata),  .s_o(sdata_s), .rise_o(sdata_rise));
    srx_sync_edge u_latch (.clk(clk), .rst_n(rst_n), .d_i(slatch), .s_o(latch_s), .rise_o(latch_rise));

    // The shift is folded in before the length check so a coincident latch sees that bit.
    always_comb begin
        shreg_d = sck_rise ? {shreg_q[FRAME_BITS-2:0], sdata_s} : shreg_q;
        cnt_sh  = (sck_rise && cnt_q != CNT_OVF) ? cnt_q + 1'b1 : cnt_q;
        accept  = latch_rise && cnt_sh == CNT_FULL;
        reject  = latch_rise ? !accept : timeout;
        cnt_d   = (latch_rise || timeout) ? '0 : cnt_sh;
        state_d = (cnt_d != '0) ? SHIFT : IDLE;
    end

`ifdef SRX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_q;
    logic unused_sig;

    assign timeout    = state_q == SHIFT && !sck_rise && idle_q == IW'(TIMEOUT_CYC - 1);
    assign unused_sig = ^{sck_s, latch_s, sdata_rise};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else idle_q <= (state_d == SHIFT && !sck_rise) ? idle_q + 1'b1 : '0;
    end
`else
    logic unused_sig;

    assign timeout    = 1'b0;
    assign unused_sig = ^{sck_s, latch_s, sdata_rise, state_q, 32'(TIMEOUT_CYC)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            frame_q     <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            busy_q      <= cnt_d != '0;
            valid_q     <= accept;
            err_pulse_q <= reject;
            if (accept) frame_q <= shreg_d;
            if (reject && err_q != '1) err_q <= err_q + 1'b1;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_pulse_q;
    assign err_cnt     = err_q;
    assign busy        = busy_q;
endmodule
